sdram_responder: RTL
====================

// Module: sdram_responder
// PURPOSE
// Synthesizable SDR SDRAM device model: the chip-side responder to our SDRAM controller.
// Decodes RAS/CAS/WE commands, tracks per-bank open rows, serves BL1 reads and writes from an
// internal backing store with programmed CAS latency, and flags protocol/timing violations.
// Used in simulation benches and on-FPGA loopback tests in place of the external SDRAM.
// PARAMETERS
// ROW_BITS      3    row bits stored per bank; upper dr_a row bits ignored (aliased)
// COL_BITS      6    column bits stored; dr_a[8:COL_BITS] ignored (aliased)
// T_RCD         2    min cycles from ACTIVE to READ/WRITE on same bank
// T_RFC         4    cycles after AREFR or LREG during which only NOP is legal
// REFR_MAX      400  max cycles between AREFR commands once init_done=1
// PORTS
// clk          in   1   clock; all commands sampled on rising edge
// rst_n        in   1   synchronous reset, active low
// dr_cs_n      in   1   chip select; command ignored (treated as NOP) when 1
// dr_cke       in   1   clock enable; when 0 the command is ignored and the read pipeline holds
// dr_ras_n     in   1   command bit 2
// dr_cas_n     in   1   command bit 1
// dr_we_n      in   1   command bit 0
// dr_ba        in   2   bank address
// dr_a         in   13  row (ACTIVE), {A10, col[8:0]} (READ/WRITE), mode (LREG)
// dr_dqml      in   1   low-byte mask (write: skip byte; read: drive 8'h00)
// dr_dqmh      in   1   high-byte mask, same rules
// dr_dq_in     in   16  write data, sampled with WRITE
// dr_dq_out    out  16  read data
// dr_dq_oe     out  1   1 while dr_dq_out carries read data
// init_done    out  1   1 after PRECH-all, 2x AREFR, LREG seen in that order
// err          out  1   sticky protocol error flag
// err_code     out  3   code of first error; held until reset
// BEHAVIOUR
// Reset: dr_dq_out=0, dr_dq_oe=0, init_done=0, err=0, err_code=0; all banks idle; CL=2;
//   read pipeline flushed; refresh counter=0; backing store NOT cleared. Reset mid-read: oe=0 next cycle.
// Commands {ras,cas,we}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 AREF, 000 LREG.
// Init FSM: WAIT_PRE -> (PRE, A10=1) -> WAIT_REF1 -> AREF -> WAIT_REF2 -> AREF -> WAIT_LREG -> LREG -> DONE.
//   NOP legal throughout; any other command before DONE -> err_code 1, FSM stays in current state.
// LREG: CL=dr_a[6:4]; only 2 or 3 accepted, else keep old CL and err_code 1. Burst length fixed at 1.
// ACT: bank must be idle (else code 2); stores row=dr_a[ROW_BITS-1:0], starts per-bank tRCD counter.
// RD/WR: bank must be active (else code 3); fewer than T_RCD cycles since ACT -> code 4.
//   A10=1: auto-precharge, bank idle after the access. Address = {ba, row, dr_a[COL_BITS-1:0]}.
// WR: dr_dq_in written same edge as command; byte lanes gated by dqml/dqmh.
// RD: mem word read at command edge (n); dr_dq_out/oe=1 updated at edge n+CL-1, valid for sampling
//   at edge n+CL; oe drops after one cycle unless another RD follows. Masked bytes drive 8'h00.
//   Pending read data and a WRITE in the same output cycle -> code 7; read still completes.
// PRE: A10=1 all banks idle, else bank dr_ba idle; PRE on idle bank is legal (no-op).
// AREF: all banks must be idle (else code 5); resets refresh counter; non-NOP within T_RFC -> code 7.
// Refresh counter: after init_done, counts each cycle; reaching REFR_MAX -> code 6 (saturates).
// Error: err set on first violation; err_code keeps first code; later violations ignored.
//   Offending command is not executed (memory/bank state unchanged).
// Same-edge events: command decode precedes counter expiry check; AREF at count REFR_MAX-1 is legal.
// TESTING
// Init: PRE(A10=1), NOPx1, AREF, NOPx4, AREF, NOPx4, LREG a=13'h0120 -> init_done=1, CL=2, err=0.
// ACT b1 r2, NOP, WR c5 d=16'hBEEF A10=1, NOP, ACT b1 r2, NOP, RD c5 -> dr_dq_out=16'hBEEF, oe=1 at edge n+2.
// WR 16'h1234 then WR 16'hABCD with dqmh=1, RD same addr -> 16'h12CD; RD with dqml=1 -> 16'h1200.
// RD to idle bank 2 -> err=1, err_code=3; following ACT on open bank -> err_code stays 3.
// No AREF for 400 cycles after init -> err_code=6; separate run with AREF every 350 -> err=0.
// LREG CL=3, RD issued, rst_n=0 at edge n+1 -> oe never asserts, init_done=0, CL back to 2.

Source files
------------

// File: rtl/sdram_responder.sv
// SDR SDRAM chip-side responder: command decode, per-bank open-row tracking,
// BL1 backing store with programmable CAS latency and a sticky protocol error.
module sdram_responder #(
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RFC    = 4,
  parameter int unsigned REFR_MAX = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dr_cs_n,
  input  logic        dr_cke,
  input  logic        dr_ras_n,
  input  logic        dr_cas_n,
  input  logic        dr_we_n,
  input  logic [1:0]  dr_ba,
  input  logic [12:0] dr_a,
  input  logic        dr_dqml,
  input  logic        dr_dqmh,
  input  logic [15:0] dr_dq_in,
  output logic [15:0] dr_dq_out,
  output logic        dr_dq_oe,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam int unsigned NBANK = 4;
  localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned RCD_W = $clog2(T_RCD + 1);
  localparam int unsigned RFC_W = $clog2(T_RFC + 1);
  localparam int unsigned REF_W = $clog2(REFR_MAX + 1);

  typedef enum logic [2:0] {
    CMD_LREG = 3'b000, CMD_AREF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR   = 3'b100, CMD_RD   = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ST_WAIT_PRE, ST_WAIT_REF1, ST_WAIT_REF2, ST_WAIT_LREG, ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                init_done_q, init_done_d;
  logic [NBANK-1:0]    bank_act_q, bank_act_d;
  logic [ROW_BITS-1:0] bank_row_q [NBANK];
  logic [ROW_BITS-1:0] bank_row_d [NBANK];
  logic [RCD_W-1:0]    rcd_q [NBANK];
  logic [RCD_W-1:0]    rcd_d [NBANK];
  logic [RFC_W-1:0]    rfc_q, rfc_d;
  logic [REF_W-1:0]    refr_q, refr_d;
  logic                cl3_q, cl3_d;
  logic                pipe0_v_q, pipe0_v_d, pipe1_v_q, pipe1_v_d;
  logic [15:0]         pipe0_d_q, pipe0_d_d, pipe1_d_q, pipe1_d_d;
  logic                oe_q, oe_d;
  logic [15:0]         dq_q, dq_d;
  logic                err_q, err_d;
  logic [2:0]          code_q, code_d;

  logic [15:0]         mem_q [DEPTH];
  cmd_e                cmd;
  logic [2:0]          viol;
  logic                init_ok, exec, cl_ok, a10, refr_hit, wr_en;
  logic [AW-1:0]       addr;
  logic [15:0]         rd_word, rd_masked;
  logic                unused_a;

  assign unused_a  = ^dr_a;
  assign a10       = dr_a[10];
  assign cl_ok     = (dr_a[6:4] == 3'd2) || (dr_a[6:4] == 3'd3);
  assign addr      = {dr_ba, bank_row_q[dr_ba], dr_a[COL_BITS-1:0]};
  assign rd_word   = mem_q[addr];
  assign rd_masked = {dr_dqmh ? 8'h00 : rd_word[15:8], dr_dqml ? 8'h00 : rd_word[7:0]};

  // Effective command: deselect, clock-disable and burst-stop all act as NOP.
  always_comb begin
    cmd = CMD_NOP;
    if (!dr_cs_n && dr_cke) cmd = cmd_e'({dr_ras_n, dr_cas_n, dr_we_n});
    if (cmd == CMD_BST) cmd = CMD_NOP;
  end

  // Violation check; a non-zero code blocks execution of the command.
  always_comb begin
    viol    = 3'd0;
    init_ok = 1'b0;
    if (cmd != CMD_NOP) begin
      if (rfc_q != '0) begin
        viol = 3'd7;
      end else if (state_q != ST_DONE) begin
        case (state_q)
          ST_WAIT_PRE:                init_ok = (cmd == CMD_PRE) && a10;
          ST_WAIT_REF1, ST_WAIT_REF2: init_ok = (cmd == CMD_AREF);
          ST_WAIT_LREG:               init_ok = (cmd == CMD_LREG) && cl_ok;
          default:                    init_ok = 1'b0;
        endcase
        if (!init_ok) viol = 3'd1;
      end else begin
        case (cmd)
          CMD_ACT: if (bank_act_q[dr_ba]) viol = 3'd2;
          CMD_RD, CMD_WR: begin
            if (!bank_act_q[dr_ba])               viol = 3'd3;
            else if (rcd_q[dr_ba] != '0)          viol = 3'd4;
            else if ((cmd == CMD_WR) && oe_q)     viol = 3'd7;
          end
          CMD_AREF: if (|bank_act_q) viol = 3'd5;
          CMD_LREG: if (!cl_ok) viol = 3'd1;
          default: ;
        endcase
      end
    end
  end

  assign exec     = (cmd != CMD_NOP) && (viol == 3'd0);
  assign refr_hit = init_done_q && (refr_q == REF_W'(REFR_MAX - 1)) &&
                    !(exec && (cmd == CMD_AREF));

  // Init sequencer next state: each legal init command advances one step.
  always_comb begin
    state_d = state_q;
    if (exec) begin
      case (state_q)
        ST_WAIT_PRE:  state_d = ST_WAIT_REF1;
        ST_WAIT_REF1: state_d = ST_WAIT_REF2;
        ST_WAIT_REF2: state_d = ST_WAIT_LREG;
        ST_WAIT_LREG: state_d = ST_DONE;
        default:      state_d = state_q;
      endcase
    end
    init_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_PRE;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
    end
  end

  // Bank, timer, read pipeline and error next state.
  always_comb begin
    bank_act_d = bank_act_q;
    bank_row_d = bank_row_q;
    rcd_d      = rcd_q;
    rfc_d      = rfc_q;
    refr_d     = refr_q;
    cl3_d      = cl3_q;
    pipe0_v_d  = pipe0_v_q;
    pipe0_d_d  = pipe0_d_q;
    pipe1_v_d  = pipe1_v_q;
    pipe1_d_d  = pipe1_d_q;
    oe_d       = oe_q;
    dq_d       = dq_q;
    err_d      = err_q;
    code_d     = code_q;
    wr_en      = 1'b0;

    for (int unsigned b = 0; b < NBANK; b++) begin
      if (rcd_q[2'(b)] != '0) rcd_d[2'(b)] = rcd_q[2'(b)] - RCD_W'(1);
    end
    if (rfc_q != '0) rfc_d = rfc_q - RFC_W'(1);
    if (init_done_q && (refr_q != REF_W'(REFR_MAX))) refr_d = refr_q + REF_W'(1);

    if (exec) begin
      case (cmd)
        CMD_ACT: begin
          bank_act_d[dr_ba] = 1'b1;
          bank_row_d[dr_ba] = dr_a[ROW_BITS-1:0];
          rcd_d[dr_ba]      = RCD_W'(T_RCD - 1);
        end
        CMD_RD, CMD_WR: begin
          wr_en = (cmd == CMD_WR);
          if (a10) bank_act_d[dr_ba] = 1'b0;
        end
        CMD_PRE: begin
          if (a10) bank_act_d = '0;
          else     bank_act_d[dr_ba] = 1'b0;
        end
        CMD_AREF: begin
          refr_d = '0;
          rfc_d  = RFC_W'(T_RFC);
        end
        CMD_LREG: begin
          cl3_d = (dr_a[6:4] == 3'd3);
          rfc_d = RFC_W'(T_RFC);
        end
        default: ;
      endcase
    end

    // CL=2 drives from stage 0, CL=3 from stage 1; CKE low freezes everything.
    if (dr_cke) begin
      pipe0_v_d = exec && (cmd == CMD_RD);
      pipe0_d_d = rd_masked;
      pipe1_v_d = pipe0_v_q;
      pipe1_d_d = pipe0_d_q;
      oe_d      = cl3_q ? pipe1_v_q : pipe0_v_q;
      dq_d      = oe_d ? (cl3_q ? pipe1_d_q : pipe0_d_q) : 16'h0000;
    end

    if (!err_q) begin
      if (viol != 3'd0) begin
        err_d  = 1'b1;
        code_d = viol;
      end else if (refr_hit) begin
        err_d  = 1'b1;
        code_d = 3'd6;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_act_q <= '0;
      bank_row_q <= '{default: '0};
      rcd_q      <= '{default: '0};
      rfc_q      <= '0;
      refr_q     <= '0;
      cl3_q      <= 1'b0;
      pipe0_v_q  <= 1'b0;
      pipe0_d_q  <= '0;
      pipe1_v_q  <= 1'b0;
      pipe1_d_q  <= '0;
      oe_q       <= 1'b0;
      dq_q       <= '0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      bank_act_q <= bank_act_d;
      bank_row_q <= bank_row_d;
      rcd_q      <= rcd_d;
      rfc_q      <= rfc_d;
      refr_q     <= refr_d;
      cl3_q      <= cl3_d;
      pipe0_v_q  <= pipe0_v_d;
      pipe0_d_q  <= pipe0_d_d;
      pipe1_v_q  <= pipe1_v_d;
      pipe1_d_q  <= pipe1_d_d;
      oe_q       <= oe_d;
      dq_q       <= dq_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  // Backing store survives reset; byte lanes gated by the data masks.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      if (!dr_dqml) mem_q[addr][7:0]  <= dr_dq_in[7:0];
      if (!dr_dqmh) mem_q[addr][15:8] <= dr_dq_in[15:8];
    end
  end

  assign dr_dq_out = dq_q;
  assign dr_dq_oe  = oe_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
